// File: rtl/check_seq_ctrl.sv
// check_seq_ctrl: loads a wide locking key into a check core word by word,
// launches the core on request, waits for its result (with a timeout) and
// presents the captured result until the consumer takes it.
//
// Ports
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   key_wr_valid/ready/data 32-bit key word stream, word 0 first (LSB-first)
//   run_valid/ready         run request handshake (accepted only when armed)
//   core_start              ap_start to the check core
//   core_done/idle/ready    ap_done / ap_idle / ap_ready from the core
//   core_return             ap_return from the core
//   core_key                locking_key to the core (held while the core runs)
//   res_valid/ready         result handshake
//   res_data/pass/timeout   captured result, pass flag, timeout flag
//   busy                    a run is in progress or its result is pending
module check_seq_ctrl #(
  parameter int unsigned KEY_W   = 12287,
  parameter int unsigned TIMEOUT = 65535,
  parameter logic [31:0] GOLDEN  = 32'h0000_0001
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             key_wr_valid,
  output logic             key_wr_ready,
  input  logic [31:0]      key_wr_data,
  input  logic             run_valid,
  output logic             run_ready,
  output logic             core_start,
  input  logic             core_done,
  input  logic             core_idle,
  input  logic             core_ready,
  input  logic [31:0]      core_return,
  output logic [KEY_W-1:0] core_key,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_pass,
  output logic             res_timeout,
  output logic             busy
);

  localparam int unsigned NW = (KEY_W + 31) / 32;
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARMED, S_START, S_WAIT, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            start_d;
  logic [31:0]     data_d;
  logic            pass_d, to_d;
  logic            key_we;
  logic [CW-1:0]   wr_idx;

  // A pending run request blocks key writes while armed.
  assign key_wr_ready = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                        ((state_q == S_ARMED) && !run_valid);
  assign key_we       = key_wr_valid && key_wr_ready;
  // Any write outside LOAD restarts the key at word 0.
  assign wr_idx       = (state_q == S_LOAD) ? cnt_q : '0;

  // Key word registers; the top word keeps only the bits below KEY_W.
  for (genvar w = 0; w < NW; w++) begin : g_key
    localparam int unsigned LO = 32 * w;
    localparam int unsigned WB = ((KEY_W - LO) < 32) ? (KEY_W - LO) : 32;
    logic [WB-1:0] word_q;
    always_ff @(posedge ap_clk) begin
      if (ap_rst)                                word_q <= '0;
      else if (key_we && (wr_idx == CW'(w)))     word_q <= key_wr_data[WB-1:0];
    end
    assign core_key[LO +: WB] = word_q;
  end

  // Next-state, counters and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    data_d  = res_data;
    pass_d  = res_pass;
    to_d    = res_timeout;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (key_we) begin
          cnt_d   = CW'(1);
          state_d = (NW == 1) ? S_ARMED : S_LOAD;
        end
      end
      S_LOAD: begin
        if (key_we) begin
          if (cnt_q == CW'(NW - 1)) state_d = S_ARMED;
          else                      cnt_d   = cnt_q + CW'(1);
        end
      end
      S_ARMED: begin
        if (run_valid) begin
          state_d = S_START;
          tcnt_d  = '0;
        end else if (key_we) begin
          cnt_d   = CW'(1);
          state_d = (NW == 1) ? S_ARMED : S_LOAD;
        end
      end
      S_START, S_WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        // done wins over both timeout and the START->WAIT handoff
        if (core_done) begin
          state_d = S_RESP;
          data_d  = core_return;
          pass_d  = (core_return == GOLDEN);
          to_d    = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          data_d  = '0;
          pass_d  = 1'b0;
          to_d    = 1'b1;
        end else if ((state_q == S_START) && core_start && core_ready) begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (res_ready) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
    // Raise start only once the core is idle, then hold it until ap_ready.
    start_d = (state_d == S_START) && (core_start || core_idle);
  end

  // State and registered outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      core_start  <= 1'b0;
      run_ready   <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      res_data    <= '0;
      res_pass    <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      core_start  <= start_d;
      run_ready   <= (state_d == S_ARMED);
      res_valid   <= (state_d == S_RESP);
      busy        <= (state_d == S_START) || (state_d == S_WAIT) ||
                     (state_d == S_RESP);
      res_data    <= data_d;
      res_pass    <= pass_d;
      res_timeout <= to_d;
    end
  end

endmodule

// File: tb/tb_check_seq_ctrl.sv
// Testbench for check_seq_ctrl: table of core behaviours, hand-written corner
// sequences and randomized runs, all checked against a key/result model.
module tb_check_seq_ctrl;

  localparam int unsigned KEY_W = 12287;
  localparam int unsigned TMO   = 16;
  localparam int unsigned NW    = (KEY_W + 31) / 32;
  localparam logic [31:0] GOLD  = 32'h0000_0001;
  localparam logic [NW*32-1:0] KMASK = {(NW*32){1'b1}} >> (NW*32 - KEY_W);

  logic             ap_clk, ap_rst;
  logic             key_wr_valid, key_wr_ready;
  logic [31:0]      key_wr_data;
  logic             run_valid, run_ready;
  logic             core_start, core_done, core_idle, core_ready;
  logic [31:0]      core_return;
  logic [KEY_W-1:0] core_key;
  logic             res_valid, res_ready;
  logic [31:0]      res_data;
  logic             res_pass, res_timeout, busy;

  check_seq_ctrl #(.KEY_W(KEY_W), .TIMEOUT(TMO), .GOLDEN(GOLD)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .key_wr_valid(key_wr_valid), .key_wr_ready(key_wr_ready), .key_wr_data(key_wr_data),
    .run_valid(run_valid), .run_ready(run_ready),
    .core_start(core_start), .core_done(core_done), .core_idle(core_idle),
    .core_ready(core_ready), .core_return(core_return), .core_key(core_key),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_pass(res_pass), .res_timeout(res_timeout), .busy(busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Behavioural HLS core: ap_ready with the accepted start, ap_done 'lat'
  // cycles later; a hung core goes idle again after 'lat' cycles with no done.
  int          cm_lat  = 5;
  logic [31:0] cm_ret  = 32'h1;
  bit          cm_hang = 1'b0;
  bit          c_busy  = 1'b0;
  int          c_cnt   = 0;
  bit          man     = 1'b0;
  logic        m_done = 1'b0, m_idle = 1'b1, m_ready = 1'b0;
  logic [31:0] m_ret  = '0;

  always @(posedge ap_clk) begin
    if (c_busy) begin
      if (c_cnt <= 1) c_busy <= 1'b0;
      c_cnt <= c_cnt - 1;
    end else if (core_start && !man) begin
      c_busy <= 1'b1;
      c_cnt  <= cm_lat;
    end
  end

  assign core_idle   = man ? m_idle  : !c_busy;
  assign core_ready  = man ? m_ready : (core_start && !c_busy);
  assign core_done   = man ? m_done  : (c_busy && (c_cnt == 1) && !cm_hang);
  assign core_return = man ? m_ret   : cm_ret;

  // Key model: an array of words plus the next load position.
  logic [31:0] mkey [NW];
  int          mpos;
  bit          mload;
  int          checks = 0;
  int          errors = 0;

  function automatic void mreset();
    for (int w = 0; w < NW; w++) mkey[w] = '0;
    mpos  = 0;
    mload = 1'b0;
  endfunction

  function automatic void model_wr(input logic [31:0] d);
    int idx;
    idx       = mload ? mpos : 0;
    mkey[idx] = d;
    mpos      = idx + 1;
    mload     = (mpos < NW);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_key(input string nm);
    logic [NW*32-1:0] g, f;
    int bad;
    g = '0;
    g[KEY_W-1:0] = core_key;
    for (int w = 0; w < NW; w++) f[32*w +: 32] = mkey[w];
    f = f & KMASK;
    bad = -1;
    for (int w = 0; w < NW; w++)
      if (bad < 0 && g[32*w +: 32] !== f[32*w +: 32]) bad = w;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: key word %0d got %0h expected %0h", nm, bad,
               g[32*bad +: 32], f[32*bad +: 32]);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    mreset();
  endtask

  task automatic wr_words(input int n, input int base, input bit rnd);
    logic [31:0] d;
    bit ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 32'($urandom) : 32'(base + i);
      key_wr_valid = 1'b1;
      key_wr_data  = d;
      #1;
      if (key_wr_ready) model_wr(d);
      else ok = 1'b0;
      tick();
    end
    key_wr_valid = 1'b0;
    chk("wr_ready_during_load", 64'(ok), 64'd1);
  endtask

  // One run: request, wait for the result, hold it 'hold' cycles, accept it.
  task automatic run(input int lat, input logic [31:0] ret, input bit hang, input int hold,
                     output int ncyc, output logic [31:0] d, output bit p, output bit to,
                     output bit saw);
    int g;
    bit stable;
    cm_lat = lat; cm_ret = ret; cm_hang = hang;
    run_valid = 1'b1;
    #1;
    g = 0;
    while (!run_ready && g < 20) begin tick(); g++; end
    chk("run_accept", 64'(run_ready), 64'd1);
    tick();
    run_valid = 1'b0;
    ncyc = 0;
    saw  = 1'b0;
    while (!res_valid && ncyc < 200) begin
      if (core_start) saw = 1'b1;
      tick();
      ncyc++;
    end
    chk("res_valid_seen", 64'(res_valid), 64'd1);
    d = res_data; p = res_pass; to = res_timeout;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!res_valid || res_data !== d || res_pass !== p || res_timeout !== to) stable = 1'b0;
    end
    if (hold > 0) chk("res_stable", 64'(stable), 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  typedef struct {
    int          lat;
    logic [31:0] ret;
    bit          hang;
    logic [31:0] edata;
    bit          epass;
    bit          eto;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n, lat, hold;
    logic [31:0] d, ret;
    bit p, to, saw, eto;

    tbl[0] = '{5,  32'h1,    1'b0, 32'h1,    1'b1, 1'b0};
    tbl[1] = '{3,  32'hDEAD, 1'b0, 32'hDEAD, 1'b0, 1'b0};
    tbl[2] = '{1,  32'h0,    1'b0, 32'h0,    1'b0, 1'b0};
    tbl[3] = '{15, 32'h1,    1'b0, 32'h1,    1'b1, 1'b0};  // done on last allowed cycle
    tbl[4] = '{16, 32'h1,    1'b0, 32'h0,    1'b0, 1'b1};  // one cycle too late
    tbl[5] = '{40, 32'h1,    1'b1, 32'h0,    1'b0, 1'b1};

    ap_rst = 1'b1; key_wr_valid = 1'b0; key_wr_data = '0;
    run_valid = 1'b0; res_ready = 1'b0;
    mreset();
    repeat (3) tick();
    ap_rst = 1'b0;

    // Reset state
    chk("rst_key_wr_ready", 64'(key_wr_ready), 64'd1);
    chk("rst_run_ready", 64'(run_ready), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_pass", 64'(res_pass), 64'd0);
    chk("rst_res_timeout", 64'(res_timeout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk_key("rst_key");

    // Partial load with a stalled run request, then reset discards it
    run_valid = 1'b1;
    wr_words(100, 0, 1'b0);
    chk("stall_run_ready_load", 64'(run_ready), 64'd0);
    chk("stall_busy_load", 64'(busy), 64'd0);
    chk_key("partial_key");
    run_valid = 1'b0;
    do_reset();
    chk_key("key_after_reset");
    chk("run_ready_after_reset", 64'(run_ready), 64'd0);
    wr_words(NW - 1, 0, 1'b0);
    chk("run_ready_one_short", 64'(run_ready), 64'd0);
    wr_words(1, NW - 1, 1'b0);
    chk("run_ready_full", 64'(run_ready), 64'd1);
    chk_key("full_key");
    chk("key_word0", 64'(core_key[31:0]), 64'd0);
    chk("key_word1", 64'(core_key[63:32]), 64'd1);

    // Golden run, 5-cycle core
    run(5, 32'h1, 1'b0, 0, n, d, p, to, saw);
    chk("golden_data", 64'(d), 64'h1);
    chk("golden_pass", 64'(p), 64'd1);
    chk("golden_timeout", 64'(to), 64'd0);
    chk_key("key_held_golden");

    // Core behaviour table
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].lat, tbl[i].ret, tbl[i].hang, 1, n, d, p, to, saw);
      chk($sformatf("tbl%0d_data", i), 64'(d), 64'(tbl[i].edata));
      chk($sformatf("tbl%0d_pass", i), 64'(p), 64'(tbl[i].epass));
      chk($sformatf("tbl%0d_timeout", i), 64'(to), 64'(tbl[i].eto));
      if (tbl[i].eto) repeat (50) tick();
    end
    chk_key("key_held_table");

    // Timeout timing, then a run that must wait for the still-busy core
    run(40, 32'h1, 1'b1, 0, n, d, p, to, saw);
    chk("to_cycles", 64'(n), 64'(TMO));
    chk("to_flag", 64'(to), 64'd1);
    chk("to_data", 64'(d), 64'd0);
    chk("to_pass", 64'(p), 64'd0);
    run(3, 32'h1, 1'b0, 0, n, d, p, to, saw);
    chk("busy_core_no_start", 64'(saw), 64'd0);
    chk("busy_core_to_cycles", 64'(n), 64'(TMO));
    chk("busy_core_to_flag", 64'(to), 64'd1);
    repeat (50) tick();
    run(3, 32'h1, 1'b0, 0, n, d, p, to, saw);
    chk("after_to_start_seen", 64'(saw), 64'd1);
    chk("after_to_pass", 64'(p), 64'd1);

    // Result held for 10 cycles, then the key is reused
    run(2, 32'h1234, 1'b0, 10, n, d, p, to, saw);
    chk("hold_data", 64'(d), 64'h1234);
    chk("hold_pass", 64'(p), 64'd0);
    chk("hold_back_armed", 64'(run_ready), 64'd1);
    run(4, 32'h1, 1'b0, 0, n, d, p, to, saw);
    chk("reuse_pass", 64'(p), 64'd1);
    chk_key("reuse_key");

    // Run and key write together while armed: run wins, key untouched
    cm_lat = 4; cm_ret = 32'h1; cm_hang = 1'b0;
    run_valid = 1'b1; key_wr_valid = 1'b1; key_wr_data = 32'hFFFF_FFFF;
    #1;
    chk("both_key_wr_ready", 64'(key_wr_ready), 64'd0);
    chk("both_run_ready", 64'(run_ready), 64'd1);
    tick();
    run_valid = 1'b0; key_wr_valid = 1'b0;
    chk("both_busy", 64'(busy), 64'd1);
    chk_key("both_key");
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    chk("both_res_valid", 64'(res_valid), 64'd1);
    chk("both_res_pass", 64'(res_pass), 64'd1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;

    // ap_ready and ap_done together in the first START cycle
    man = 1'b1; m_idle = 1'b1; m_ready = 1'b0; m_done = 1'b0; m_ret = 32'hDEAD;
    run_valid = 1'b1;
    #1;
    tick();
    run_valid = 1'b0;
    chk("same_cycle_start", 64'(core_start), 64'd1);
    m_ready = 1'b1; m_done = 1'b1;
    tick();
    m_ready = 1'b0; m_done = 1'b0;
    chk("same_cycle_res_valid", 64'(res_valid), 64'd1);
    chk("same_cycle_data", 64'(res_data), 64'hDEAD);
    chk("same_cycle_pass", 64'(res_pass), 64'd0);
    chk("same_cycle_timeout", 64'(res_timeout), 64'd0);
    chk("same_cycle_start_drop", 64'(core_start), 64'd0);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    man = 1'b0;

    // Writing while armed restarts the load at word 0
    wr_words(1, 0, 1'b1);
    chk("reload_run_ready", 64'(run_ready), 64'd0);
    chk_key("reload_word0");
    wr_words(NW - 1, 0, 1'b1);
    chk("reload_done", 64'(run_ready), 64'd1);
    chk_key("reload_key");

    // Randomized runs with occasional full random reloads
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_words(NW, 0, 1'b1);
        chk_key($sformatf("rnd%0d_key", r));
      end
      lat  = $urandom_range(1, 20);
      ret  = ($urandom_range(0, 1) == 1) ? GOLD : 32'($urandom);
      hold = $urandom_range(0, 4);
      eto  = (lat >= TMO);
      run(lat, ret, 1'b0, hold, n, d, p, to, saw);
      chk($sformatf("rnd%0d_data", r), 64'(d), eto ? 64'd0 : 64'(ret));
      chk($sformatf("rnd%0d_pass", r), 64'(p), 64'(!eto && ret == GOLD));
      chk($sformatf("rnd%0d_timeout", r), 64'(to), 64'(eto));
      if (eto) repeat (30) tick();
    end
    chk_key("rnd_key_final");

    // Reset mid-WAIT; the late core_done must be ignored
    cm_lat = 10; cm_ret = 32'h1; cm_hang = 1'b0;
    run_valid = 1'b1;
    #1;
    tick();
    run_valid = 1'b0;
    repeat (3) tick();
    do_reset();
    saw = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (res_valid || busy || core_start) saw = 1'b1;
      tick();
    end
    chk("rst_wait_quiet", 64'(saw), 64'd0);
    chk_key("rst_wait_key");
    chk("rst_wait_key_wr_ready", 64'(key_wr_ready), 64'd1);
    chk("rst_wait_run_ready", 64'(run_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
